tone_detector: RTL and testbench



---
 rtl/tone_detector_pkg.sv | 36 +++
 rtl/tone_channel.sv | 47 ++++
 rtl/tone_detector.sv | 132 +++++++++++++
 tb/tb_tone_detector.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_detector_pkg.sv
// Shared definitions for the tone detector and the drive FSM that consumes its
// junction command: direction codes, detector states and channel indices.
package tone_detector_pkg;

  localparam int NUM_CH      = 5;
  localparam int CNT_W       = 16;
  localparam int CH_STRAIGHT = 0;
  localparam int CH_LEFT     = 1;
  localparam int CH_RIGHT    = 2;
  localparam int CH_BACK     = 3;
  localparam int CH_BEACON   = 4;

  typedef enum logic [1:0] {
    DIR_STRAIGHT = 2'b00,
    DIR_LEFT     = 2'b01,
    DIR_RIGHT    = 2'b10,
    DIR_BACK     = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_CONFIRM = 2'b01,
    ST_LOCKED  = 2'b10
  } state_e;

  // Index of the set direction bit; only meaningful when exactly one is set.
  function automatic dir_e dir_of(input logic [3:0] dirs);
    dir_e d;
    d = DIR_STRAIGHT;
    for (int i = 0; i < 4; i++) begin
      if (dirs[i]) d = dir_e'(i[1:0]);
    end
    return d;
  endfunction

endpackage

// File: rtl/tone_channel.sv
// One comparator channel: synchronizer, rising-edge detector, saturating
// per-window edge counter and the presence decision taken on the window tick.
module tone_channel
  import tone_detector_pkg::*;
#(
  parameter int MIN_EDGES = 40
) (
  input  logic clk,
  input  logic rst_n,
  input  logic bp,
  input  logic tick,
  output logic present
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_EDGES);

  logic             sync_p0;
  logic             sync_p1;
  logic             prev_p2;
  logic             edge_det;
  logic [CNT_W-1:0] cnt;

  assign edge_det = sync_p1 & ~prev_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
      cnt     <= '0;
      present <= 1'b0;
    end else begin
      sync_p0 <= bp;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
      // An edge on the tick cycle seeds the next window instead of closing this one.
      if (tick) begin
        cnt     <= edge_det ? CNT_W'(1) : '0;
        present <= (cnt >= MIN_CNT);
      end else if (edge_det && cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/tone_detector.sv
// Junction tone detector: five tone channels, a measurement window counter and a
// per-window confirm/lock/loss state machine producing tdEn/tdDir.
module tone_detector
  import tone_detector_pkg::*;
#(
  parameter int WINDOW_CYCLES   = 500_000,
  parameter int MIN_EDGES       = 40,
  parameter int CONFIRM_WINDOWS = 3,
  parameter int LOSS_WINDOWS    = 2
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       bp1,
  input  logic       bp2,
  input  logic       bp3,
  input  logic       bp4,
  input  logic       bp5,
  output logic       tdEn,
  output logic [1:0] tdDir,
  output logic [4:0] tdPresent
);

  localparam int              WIN_W     = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [7:0]      CONFIRM_N = 8'(CONFIRM_WINDOWS);
  localparam logic [7:0]      LOSS_N    = 8'(LOSS_WINDOWS);

  logic [NUM_CH-1:0] bp_vec;
  logic [NUM_CH-1:0] present;
  logic [WIN_W-1:0]  win_cnt;
  logic              tick;
  logic              eval_p1;
  logic [3:0]        dir_hot;
  logic              valid;
  dir_e              cand_new;
  dir_e              cand;
  state_e            state;
  logic [7:0]        confirm_cnt;
  logic [7:0]        loss_cnt;

  assign bp_vec = {bp5, bp4, bp3, bp2, bp1};

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    tone_channel #(
      .MIN_EDGES(MIN_EDGES)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rstN),
      .bp     (bp_vec[n]),
      .tick   (tick),
      .present(present[n])
    );
  end

  assign tdPresent = present;
  assign tick      = (win_cnt == WIN_LAST);

  // Stage p1: the FSM runs in the cycle after the presence flags refresh.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      win_cnt <= '0;
      eval_p1 <= 1'b0;
    end else begin
      eval_p1 <= tick;
      win_cnt <= tick ? '0 : win_cnt + WIN_W'(1);
    end
  end

  assign dir_hot  = present[CH_BACK:CH_STRAIGHT];
  assign valid    = present[CH_BEACON] && $onehot(dir_hot);
  assign cand_new = dir_of(dir_hot);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state       <= ST_IDLE;
      cand        <= DIR_STRAIGHT;
      confirm_cnt <= '0;
      loss_cnt    <= '0;
      tdEn        <= 1'b0;
      tdDir       <= DIR_STRAIGHT;
    end else if (eval_p1) begin
      case (state)
        ST_IDLE: begin
          if (valid) begin
            cand        <= cand_new;
            confirm_cnt <= 8'd1;
            loss_cnt    <= '0;
            if (CONFIRM_N <= 8'd1) begin
              state <= ST_LOCKED;
              tdEn  <= 1'b1;
              tdDir <= cand_new;
            end else begin
              state <= ST_CONFIRM;
            end
          end
        end
        ST_CONFIRM: begin
          if (!valid) begin
            state       <= ST_IDLE;
            confirm_cnt <= '0;
          end else if (cand_new != cand) begin
            cand        <= cand_new;
            confirm_cnt <= 8'd1;
          end else if (confirm_cnt + 8'd1 >= CONFIRM_N) begin
            state       <= ST_LOCKED;
            confirm_cnt <= confirm_cnt + 8'd1;
            loss_cnt    <= '0;
            tdEn        <= 1'b1;
            tdDir       <= cand;
          end else begin
            confirm_cnt <= confirm_cnt + 8'd1;
          end
        end
        ST_LOCKED: begin
          // Direction is frozen here; only the beacon decides when to let go.
          if (present[CH_BEACON]) begin
            loss_cnt <= '0;
          end else if (loss_cnt + 8'd1 >= LOSS_N) begin
            state       <= ST_IDLE;
            loss_cnt    <= '0;
            confirm_cnt <= '0;
            tdEn        <= 1'b0;
          end else begin
            loss_cnt <= loss_cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tone_detector.sv
// Bench for tone_detector: scripted segments, hand-placed edge sequences and
// random tone patterns, all checked against a window-level reference model.
module tb_tone_detector;

  localparam int W    = 100;
  localparam int MIN  = 5;
  localparam int CONF = 3;
  localparam int LOSS = 2;
  localparam int MAXW = 64;

  logic       clk  = 1'b0;
  logic       rstN = 1'b1;
  logic [4:0] bp   = '0;
  logic       tdEn;
  logic [1:0] tdDir;
  logic [4:0] tdPresent;

  tone_detector #(
    .WINDOW_CYCLES  (W),
    .MIN_EDGES      (MIN),
    .CONFIRM_WINDOWS(CONF),
    .LOSS_WINDOWS   (LOSS)
  ) dut (
    .clk      (clk),
    .rstN     (rstN),
    .bp1      (bp[0]),
    .bp2      (bp[1]),
    .bp3      (bp[2]),
    .bp4      (bp[3]),
    .bp5      (bp[4]),
    .tdEn     (tdEn),
    .tdDir    (tdDir),
    .tdPresent(tdPresent)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: rising edges per window, keyed by the cycle the DUT sees them.
  int         mcnt[MAXW][5];
  logic [4:0] prev_v;
  logic [4:0] m_pres;
  logic       m_en;
  logic [1:0] m_dir;
  int         m_cand;
  int         m_streak;
  int         m_loss;

  logic       pend_on;
  int         pend_at;
  logic       pend_en;
  logic [1:0] pend_dir;
  logic [4:0] pend_pres;

  typedef struct {
    logic [4:0] chans;
    int         windows;
    logic       exp_en;
    logic [1:0] exp_dir;
    logic [4:0] exp_pres;
  } row_t;

  row_t tbl[10];
  int   plist[8] = '{2, 4, 10, 16, 20, 22, 24, 40};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cyc %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic sq(input int q, input int p);
    return (p > 0) && ((q % p) < (p / 2));
  endfunction

  task automatic model_clear();
    for (int w = 0; w < MAXW; w++)
      for (int c = 0; c < 5; c++) mcnt[w][c] = 0;
    prev_v   = '0;
    m_pres   = '0;
    m_en     = 1'b0;
    m_dir    = 2'b00;
    m_cand   = 0;
    m_streak = 0;
    m_loss   = 0;
  endtask

  // Direction is reported after CONF consecutive windows with the beacon and a
  // single, unchanged direction tone; dropped after LOSS beacon-less windows.
  task automatic model_window();
    int   ndir;
    int   d;
    logic ok;
    ndir = 0;
    d    = 0;
    for (int c = 0; c < 4; c++) if (m_pres[c]) begin ndir++; d = c; end
    ok = m_pres[4] && (ndir == 1);
    if (m_en) begin
      if (m_pres[4]) m_loss = 0;
      else begin
        m_loss++;
        if (m_loss >= LOSS) begin m_en = 1'b0; m_loss = 0; m_streak = 0; end
      end
    end else if (!ok) begin
      m_streak = 0;
    end else begin
      if (m_streak > 0 && d == m_cand) m_streak++;
      else begin m_cand = d; m_streak = 1; end
      if (m_streak >= CONF) begin m_en = 1'b1; m_dir = 2'(d); m_loss = 0; end
    end
  endtask

  task automatic advance();
    int         j;
    logic [4:0] e;
    @(posedge clk);
    cyc++;
    #1;
    if (cyc % W == 0) begin
      j = cyc / W - 1;
      for (int c = 0; c < 5; c++) e[c] = (j < MAXW) && (mcnt[j][c] >= MIN);
      m_pres = e;
      chk("present", 32'(tdPresent), 32'(m_pres));
      chk("en_hold_t1", 32'(tdEn), 32'(m_en));
      chk("dir_hold_t1", 32'(tdDir), 32'(m_dir));
    end
    if (cyc % W == 1 && cyc > 1) begin
      model_window();
      chk("en_t2", 32'(tdEn), 32'(m_en));
      chk("dir_t2", 32'(tdDir), 32'(m_dir));
    end
    if (cyc % W == 50) begin
      chk("en_mid", 32'(tdEn), 32'(m_en));
      chk("dir_mid", 32'(tdDir), 32'(m_dir));
      chk("present_mid", 32'(tdPresent), 32'(m_pres));
    end
    if (pend_on && cyc == pend_at) begin
      pend_on = 1'b0;
      chk("row_en", 32'(tdEn), 32'(pend_en));
      chk("row_dir", 32'(tdDir), 32'(pend_dir));
      chk("row_present", 32'(tdPresent), 32'(pend_pres));
    end
  endtask

  task automatic drive(input logic [4:0] v);
    int w;
    w = (cyc + 3) / W;
    for (int c = 0; c < 5; c++)
      if (v[c] && !prev_v[c] && w < MAXW) mcnt[w][c]++;
    prev_v = v;
    bp     = v;
  endtask

  task automatic do_reset();
    bp   = '0;
    rstN = 1'b0;
    #1;
    chk("rst_en", 32'(tdEn), 32'd0);
    chk("rst_dir", 32'(tdDir), 32'd0);
    chk("rst_present", 32'(tdPresent), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    model_clear();
    pend_on = 1'b0;
    cyc     = 0;
    rstN    = 1'b1;
  endtask

  initial begin
    int         d;
    int         per[5];
    int         ph[5];
    logic [4:0] v;

    tbl[0] = '{5'b10010, 5, 1'b1, 2'b01, 5'b10010};
    tbl[1] = '{5'b00010, 1, 1'b1, 2'b01, 5'b00010};
    tbl[2] = '{5'b10010, 1, 1'b1, 2'b01, 5'b10010};
    tbl[3] = '{5'b00100, 2, 1'b0, 2'b01, 5'b00100};
    tbl[4] = '{5'b10110, 3, 1'b0, 2'b01, 5'b10110};
    tbl[5] = '{5'b00010, 2, 1'b0, 2'b01, 5'b00010};
    tbl[6] = '{5'b10000, 1, 1'b0, 2'b01, 5'b10000};
    tbl[7] = '{5'b10001, 2, 1'b0, 2'b01, 5'b10001};
    tbl[8] = '{5'b11000, 3, 1'b1, 2'b11, 5'b11000};
    tbl[9] = '{5'b10001, 1, 1'b1, 2'b11, 5'b10001};

    pend_on = 1'b0;
    model_clear();
    #2;
    do_reset();

    // Acquisition, loss hysteresis, invalid patterns and candidate change.
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < tbl[r].windows * W; k++) begin
        advance();
        drive(sq(cyc, 10) ? tbl[r].chans : 5'b00000);
      end
      pend_on   = 1'b1;
      pend_at   = cyc + 1;
      pend_en   = tbl[r].exp_en;
      pend_dir  = tbl[r].exp_dir;
      pend_pres = tbl[r].exp_pres;
    end
    advance();
    drive(5'b00000);

    // Threshold: 4 edges, 5 edges, 4 edges plus one landing on the tick, then 5.
    do_reset();
    for (int k = 0; k < 5 * W; k++) begin
      advance();
      v = '0;
      v[0] = ((cyc % 10 == 0) && ((cyc >= 10  && cyc <= 40)  || (cyc >= 110 && cyc <= 150) ||
                                  (cyc >= 210 && cyc <= 240) || (cyc >= 310 && cyc <= 340)))
             || (cyc == 297);
      drive(v);
      if (cyc == 150) chk("thr_4_edges", 32'(tdPresent[0]), 32'd0);
      if (cyc == 250) chk("thr_5_edges", 32'(tdPresent[0]), 32'd1);
      if (cyc == 350) chk("thr_tick_edge_old", 32'(tdPresent[0]), 32'd0);
      if (cyc == 450) chk("thr_tick_edge_new", 32'(tdPresent[0]), 32'd1);
    end

    // Reset in the middle of CONFIRM, then full reacquisition.
    do_reset();
    for (int k = 0; k < 250; k++) begin
      advance();
      drive(sq(cyc, 10) ? 5'b10100 : 5'b00000);
    end
    chk("pre_rst_present", 32'(tdPresent), 32'h14);
    do_reset();
    for (int k = 0; k < 4 * W; k++) begin
      advance();
      drive(sq(cyc, 10) ? 5'b10100 : 5'b00000);
      if (cyc == 250) chk("reacq_early", 32'(tdEn), 32'd0);
      if (cyc == 350) begin
        chk("reacq_en", 32'(tdEn), 32'd1);
        chk("reacq_dir", 32'(tdDir), 32'd2);
      end
    end

    // Random tone mixes with mostly steady directions.
    do_reset();
    d = 0;
    for (int w = 0; w < 30; w++) begin
      if (w == 0 || $urandom_range(0, 3) == 0) d = int'($urandom_range(0, 3));
      for (int c = 0; c < 5; c++) begin
        per[c] = 0;
        ph[c]  = int'($urandom_range(0, 39));
      end
      per[d] = plist[$urandom_range(0, 7)];
      if ($urandom_range(0, 4) != 0) per[4] = plist[$urandom_range(0, 7)];
      if ($urandom_range(0, 3) == 0) per[$urandom_range(0, 3)] = plist[$urandom_range(0, 7)];
      for (int k = 0; k < W; k++) begin
        advance();
        for (int c = 0; c < 5; c++) v[c] = sq(cyc + ph[c], per[c]);
        drive(v);
      end
    end
    for (int k = 0; k < 2 * W; k++) begin
      advance();
      drive(5'b00000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
